ysyx_24100005_ifu: RTL
======================

# ysyx_24100005_ifu

Parametrised instruction fetch unit for the ysyx_24100005 NPC core. It owns the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a FIFO toward decode. It supports redirect from execute (branch/jump), which flushes buffered and in-flight instructions. It replaces the externally driven `inst` input of the current top level.

## Interface
Parameters:
- XLEN, 32, address/data width; must be 32 in this generation, kept for RV64 later
- RESET_PC, 32'h8000_0000, PC loaded on reset
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥ 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  word-aligned fetch address
- resp_valid  in  1  read data valid; always accepted, no back-pressure
- resp_data  in  32  instruction word
- out_valid  out  1  fetch queue non-empty
- out_ready  in  1  decode consumes head entry
- out_inst  out  32  head instruction
- out_pc  out  XLEN  head PC
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new PC; bits [1:0] forced to 0

## Operation
- Registers: pc, fetch_pc (address of the in-flight request), state, and the FIFO (ptr width log2(FQ_DEPTH)+1, wrap bit distinguishes full from empty).
- FSM states: REQ, WAIT, DROP. Reset → REQ. At most one request outstanding.
- REQ: req_valid = (count < FQ_DEPTH) && !rst; req_addr = pc. On req_valid && req_ready: fetch_pc ← pc, pc ← pc + 4 (wraps mod 2^XLEN), → WAIT.
- WAIT: on resp_valid, push {fetch_pc, resp_data} → REQ. Space is guaranteed by the REQ gate.
- DROP: on resp_valid, discard data → REQ. No request is issued in DROP.
- Pop: out_valid && out_ready advances the read pointer.
- Redirect (highest priority): pc ← {redirect_pc[XLEN-1:2], 2'b00}, FIFO emptied (pointers to 0); a same-cycle pop or push is ignored. Next state:
  - REQ without handshake → REQ.
  - REQ with handshake same cycle → DROP; the old-PC request is issued but killed. pc still takes redirect_pc, not pc + 4.
  - WAIT without resp_valid → DROP.
  - WAIT with resp_valid → REQ; the response is discarded.
  - DROP without resp_valid → DROP.
  - DROP with resp_valid → REQ.
- Simultaneous push and pop on a full or non-empty FIFO: both take effect, count unchanged.
- Reset mid-operation: state → REQ, pc → RESET_PC, FIFO empty. A response arriving in the cycle after reset deasserts while in REQ is ignored. The memory side must not return responses for requests issued before reset.

## Timing
- Outputs during and after reset: req_valid=0 while rst=1. out_valid=0, out_inst=0, out_pc=0 (FIFO storage cleared). req_addr=RESET_PC.
- req_valid rises in the first cycle with rst=0.
- out_* are driven directly from FIFO registers; no combinational path from resp_* to out_*.
- Latency: request accepted at cycle N; response at cycle M ≥ N+1; entry visible on out_valid at M+1; next request at M+1 at the earliest.
- Peak throughput: one instruction per 2 cycles with a 1-cycle memory.
- req_addr and req_valid stay stable while req_valid && !req_ready, unless redirect_valid is asserted.
- Redirect at cycle R: out_valid=0 at R+1; the first new request is at R+1 if the FSM is in REQ, otherwise one cycle after the pending response retires.

## Test plan
- Reset/linear fetch: release rst; 1-cycle memory returning addr^32'h1234 → out_pc sequence 8000_0000, 8000_0004, 8000_0008, each with the matching out_inst; req_valid=0 during rst.
- Back-pressure: hold out_ready=0 with FQ_DEPTH=4 → exactly 4 entries fill, req_valid stays 0. Pulse out_ready for one cycle → one pop, then one new request at 8000_0010.
- Stalled memory: req_ready=0 for 5 cycles → req_addr holds 8000_0000 and pc does not advance. Response latency of 3 cycles → correct ordering.
- Redirect during WAIT: request to 8000_0008 in flight; redirect to 8000_0101 → stale response dropped, next req_addr=8000_0100, FIFO empty at R+1.
- Redirect coinciding with handshake, and with resp_valid in WAIT → no stale entry ever reaches out_valid; next out_pc equals the redirect target.
- Reset mid-stream with a 2-entry-full FIFO → out_valid=0 and req_addr=8000_0000 in the cycle after rst is sampled high.

Source files
------------

// File: rtl/ysyx_24100005_ifu.sv
// ysyx_24100005_ifu: instruction fetch unit.
// Owns the PC and issues one word read at a time over a valid/ready request
// channel. Returned words are queued with their PCs toward decode. A redirect
// from execute restarts fetch at a new PC and flushes queued and in-flight work.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   fetch request channel (one outstanding)
//   resp_valid/resp_data       read response, always accepted
//   out_valid/out_ready/out_inst/out_pc   fetch queue head toward decode
//   redirect_valid/redirect_pc flush and restart at redirect_pc (bits [1:0] ignored)
module ysyx_24100005_ifu #(
  parameter int unsigned     XLEN     = 32,  // must be 32 in this generation
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     FQ_DEPTH = 4    // power of two, >= 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned AW = $clog2(FQ_DEPTH);
  localparam int unsigned PW = AW + 1;  // extra wrap bit separates full from empty

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [31:0]     inst_mem_q [FQ_DEPTH];
  logic [XLEN-1:0] pc_mem_q   [FQ_DEPTH];

  logic [PW-1:0]   count;
  logic            fq_full;
  logic            push;
  logic            pop;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign count   = wptr_q - rptr_q;
  assign fq_full = (count == PW'(FQ_DEPTH));

  // Queue head is read straight from storage; nothing from resp_* reaches out_*.
  assign out_valid = (wptr_q != rptr_q);
  assign out_inst  = inst_mem_q[rptr_q[AW-1:0]];
  assign out_pc    = pc_mem_q[rptr_q[AW-1:0]];
  assign req_addr  = pc_q;

  // Fetch FSM next state, request gating and PC update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    req_valid  = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      S_REQ: begin
        // Only request when the reply is guaranteed a queue slot.
        req_valid = !fq_full && !rst;
        if (req_valid && req_ready) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
          // A request accepted alongside a redirect is already stale.
          state_d    = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          push    = !redirect_valid;
          state_d = S_REQ;
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end

  // Queue pointers; a redirect empties the queue and overrides push/pop.
  always_comb begin
    pop    = out_valid && out_ready && !redirect_valid;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (redirect_valid) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
    end
  end

  // State, PC and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Queue storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wptr_q[AW-1:0]] <= resp_data;
      pc_mem_q[wptr_q[AW-1:0]]   <= fetch_pc_q;
    end
  end

endmodule
